cnn16_mem_ctrl: RTL

//   Unified 4K x 16 program/data memory with a request/ready handshake. Sits directly

---
 rtl/cnn16_mem_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cnn16_mem_ctrl.sv
// Unified program/data memory for the CNN16 CPU: request/ready handshake with a fixed
// access latency, plus a side load port that writes the array while the controller is idle.
module cnn16_mem_ctrl #(
    parameter int    ADDR_W    = 12,
    parameter int    DATA_W    = 16,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] from_memory,
    output logic              mem_ready,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q;

    logic              idle;
    logic              rd_fire;
    logic [ADDR_W-1:0] rd_addr;
    logic              load_fwd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d  = address;
                    we_d    = mem_we;
                    wdata_d = to_memory;
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reads are captured on the edge entering DONE so data and ready appear together;
    // with LATENCY=1 that edge is the accept edge, hence the live-input path and load forwarding.
    assign idle     = (state_q == S_IDLE);
    assign rd_addr  = idle ? address : addr_q;
    assign rd_fire  = ready_d && !(idle ? mem_we : we_q);
    assign load_fwd = idle && load_en && (load_addr == address);

    // Writes commit on the edge leaving DONE; loads only in IDLE, so one write port suffices.
    assign wr_en   = !reset && ((state_q == S_DONE && we_q) || (idle && load_en));
    assign wr_addr = idle ? load_addr : addr_q;
    assign wr_data = idle ? load_data : wdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_fire) begin
            rdata_q <= load_fwd ? load_data : mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
        end
    end

    assign from_memory = rdata_q;
    assign mem_ready   = ready_q;
    assign busy        = !idle;

endmodule
